neighbor_builder: RTL

NEIGHBOR_BUILDER -- requirements
Module: neighbor_builder

---
 rtl/mesh_pkg.sv | 10 +
 rtl/neighbor_builder_pair_sequencer.sv | 30 +++
 rtl/neighbor_builder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mesh_pkg.sv
// mesh_pkg: FSM state type and neighbor-record geometry shared by the mesh blocks
package mesh_pkg;
   typedef enum logic [3:0] {
      IDLE, RD_VCOUNT, RD_FCOUNT, CLEAR, RD_FACE, LOOKUP, SCAN, INSERT, NEXT_PAIR, DONE
   } nb_state_t;
   // one count word followed by the neighbor slots
   function automatic int unsigned rec_stride(input int unsigned max_neighbors);
      return max_neighbors + 1;
   endfunction
endpackage

// File: rtl/neighbor_builder_pair_sequencer.sv
// pair_sequencer: steps through the six ordered (cur, test) pairs of a triangle
// ports: clk/rst (async high); advance moves to the next pair and wraps after the sixth;
//        a/b/c face indices; cur/test current pair; valid when cur != test; last on the sixth pair
module pair_sequencer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         advance,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] cur,
   output logic [W-1:0] test,
   output logic         valid,
   output logic         last
);
   logic [2:0] sel;
   // wrapping after the sixth pair leaves the sequencer ready for the next face
   always_ff @(posedge clk or posedge rst)
      if (rst) sel <= 3'd0;
      else if (advance) sel <= sel == 3'd5 ? 3'd0 : sel + 3'd1;
   // order: (a,b) (a,c) (b,a) (b,c) (c,a) (c,b)
   always_comb begin
      cur   = sel < 3'd2 ? a : sel < 3'd4 ? b : c;
      test  = sel == 3'd0 || sel == 3'd5 ? b : sel == 3'd1 || sel == 3'd3 ? c : a;
      valid = cur != test;
      last  = sel == 3'd5;
   end
endmodule

// File: rtl/neighbor_builder.sv
// neighbor_builder: builds per-vertex neighbor lists in RAM2 from an OBJ image in RAM1
// ports: clk, rst (async, active high), start pulse; busy, done pulse, sticky overflow/bad_index;
//        RAM1_* read-only OBJ source (V, coords, F, face indices);
//        RAM2_* neighbor table, one record of count + MAX_NEIGHBOR_COUNT slots per vertex
module neighbor_builder
   import mesh_pkg::*;
#(
   parameter int DATA_W             = 32,
   parameter int ADDR_W             = 9,
   parameter int MAX_NEIGHBOR_COUNT = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              bad_index,
   output logic              RAM1_EN,
   output logic [3:0]        RAM1_WE,
   output logic [ADDR_W-1:0] RAM1_A,
   output logic [DATA_W-1:0] RAM1_Di,
   input  logic [DATA_W-1:0] RAM1_Do,
   output logic              RAM2_EN,
   output logic [3:0]        RAM2_WE,
   output logic [ADDR_W-1:0] RAM2_A,
   output logic [DATA_W-1:0] RAM2_Di,
   input  logic [DATA_W-1:0] RAM2_Do
);
   localparam int AW = ADDR_W + 4;
   localparam logic [AW-1:0] STRIDE = AW'(rec_stride(MAX_NEIGHBOR_COUNT));
   localparam logic [AW-1:0] K1 = AW'(1);
   localparam logic [AW-1:0] K2 = AW'(2);
   localparam logic [AW-1:0] K3 = AW'(3);
   localparam logic [DATA_W-1:0] ONE   = DATA_W'(1);
   localparam logic [DATA_W-1:0] TWO   = DATA_W'(2);
   localparam logic [DATA_W-1:0] THREE = DATA_W'(3);
   localparam logic [DATA_W-1:0] MAXC  = DATA_W'(MAX_NEIGHBOR_COUNT);

   nb_state_t state, nxt;
   logic [DATA_W-1:0] v_r, f_r, idx, face, sub, cnt_r, a_r, b_r, c_r;
   logic [DATA_W-1:0] cur, test, cnt_now;
   logic pvalid, plast, adv, hit, nomatch, full, face_ok, last_face, clear_end;
   logic [AW-1:0] rec, a1, a2;

   function automatic logic in_range(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] n);
      return x != '0 && x <= n;
   endfunction

   pair_sequencer #(.W(DATA_W)) u_pairs (
      .clk(clk), .rst(rst), .advance(adv),
      .a(a_r), .b(b_r), .c(c_r),
      .cur(cur), .test(test), .valid(pvalid), .last(plast)
   );

   // sub counts the read phase in RD_FACE, the slot in SCAN (0 = count word) and the write in INSERT
   always_comb begin
      cnt_now   = sub == '0 ? RAM2_Do : cnt_r;
      hit       = sub != '0 && RAM2_Do == test;
      nomatch   = sub == '0 ? RAM2_Do == '0 : sub == cnt_r;
      full      = cnt_now >= MAXC;
      face_ok   = in_range(a_r, v_r) && in_range(b_r, v_r) && in_range(RAM1_Do, v_r);
      last_face = face + ONE == f_r;
      clear_end = v_r == '0 || idx + ONE >= v_r;
      rec       = AW'(cur - ONE) * STRIDE;
      nxt       = state;
      adv       = 1'b0;
      a1        = '0;
      a2        = '0;
      RAM1_EN   = 1'b1;
      RAM1_WE   = 4'h0;
      RAM1_Di   = '0;
      RAM2_EN   = 1'b1;
      RAM2_WE   = 4'h0;
      RAM2_Di   = '0;
      case (state)
         IDLE:      nxt = start ? RD_VCOUNT : IDLE;
         // V is on the bus now, so F's address is formed from it directly
         RD_VCOUNT: begin
            a1  = AW'(RAM1_Do) * K3 + K1;
            nxt = RD_FCOUNT;
         end
         RD_FCOUNT: nxt = CLEAR;
         CLEAR: begin
            a2      = AW'(idx) * STRIDE;
            RAM2_WE = {4{v_r != '0}};
            nxt     = !clear_end ? CLEAR : v_r == '0 || f_r == '0 ? DONE : RD_FACE;
         end
         // three reads issued at sub 0..2, their data lands at sub 1..3
         RD_FACE: begin
            a1  = AW'(v_r) * K3 + K2 + AW'(face) * K3 + AW'(sub);
            nxt = sub != THREE ? RD_FACE : face_ok ? LOOKUP : last_face ? DONE : RD_FACE;
         end
         LOOKUP: begin
            a2  = rec;
            nxt = pvalid ? SCAN : NEXT_PAIR;
         end
         SCAN: begin
            a2  = rec + AW'(sub) + K1;
            nxt = hit ? NEXT_PAIR : !nomatch ? SCAN : full ? NEXT_PAIR : INSERT;
         end
         INSERT: begin
            a2      = sub == '0 ? rec + AW'(cnt_r) + K1 : rec;
            RAM2_WE = 4'hf;
            RAM2_Di = sub == '0 ? test : cnt_r + ONE;
            nxt     = sub == '0 ? INSERT : NEXT_PAIR;
         end
         NEXT_PAIR: begin
            adv = 1'b1;
            nxt = !plast ? LOOKUP : last_face ? DONE : RD_FACE;
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
      RAM1_A = a1[ADDR_W-1:0];
      RAM2_A = a2[ADDR_W-1:0];
      busy   = state != IDLE && state != DONE;
      done   = state == DONE;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         v_r       <= '0;
         f_r       <= '0;
         idx       <= '0;
         face      <= '0;
         sub       <= '0;
         cnt_r     <= '0;
         a_r       <= '0;
         b_r       <= '0;
         c_r       <= '0;
         overflow  <= 1'b0;
         bad_index <= 1'b0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: if (start) begin
               overflow  <= 1'b0;
               bad_index <= 1'b0;
            end
            RD_VCOUNT: v_r <= RAM1_Do;
            RD_FCOUNT: begin
               f_r  <= RAM1_Do;
               idx  <= '0;
               face <= '0;
               sub  <= '0;
            end
            CLEAR: idx <= idx + ONE;
            RD_FACE: begin
               sub <= sub == THREE ? '0 : sub + ONE;
               a_r <= sub == ONE ? RAM1_Do : a_r;
               b_r <= sub == TWO ? RAM1_Do : b_r;
               if (sub == THREE) begin
                  c_r <= RAM1_Do;
                  if (!face_ok) begin
                     bad_index <= 1'b1;
                     face      <= face + ONE;
                  end
               end
            end
            LOOKUP: sub <= '0;
            SCAN: begin
               cnt_r <= cnt_now;
               sub   <= hit || nomatch ? '0 : sub + ONE;
               if (!hit && nomatch && full) overflow <= 1'b1;
            end
            INSERT:    sub <= sub == '0 ? ONE : '0;
            NEXT_PAIR: if (plast) face <= face + ONE;
            default: ;
         endcase
      end
endmodule
